// File: rtl/hex_sched_pkg.sv
// Shared encodings for the HEX bank scheduler: FSM states, BCD nibble width, owner ids.
// Latency: n/a (constants and a constant-foldable helper only).
// Backpressure: n/a.
package hex_sched_pkg;

  localparam int BCD_W = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_LOAD    = 2'd2;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // 10^n as a 64-bit value; used for the saturation threshold.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/hex_display_sched_if.sv
// Request/grant and display bus between the value sources, the scheduler and the decoders.
// Latency: n/a (wires only).
// Backpressure: level requests held by the source until a one-cycle grant pulse returns.
interface hex_display_sched_if
  import hex_sched_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VAL_W      = 20
);
  logic                          req_a;
  logic [VAL_W-1:0]              val_a;
  logic                          req_b;
  logic [VAL_W-1:0]              val_b;
  logic                          grant_a;
  logic                          grant_b;
  logic [BCD_W*NUM_DIGITS-1:0]   digits;
  logic [NUM_DIGITS-1:0]         blank;
  logic                          owner;
  logic                          busy;
  logic                          ovf;

  modport master (
    output req_a, val_a, req_b, val_b,
    input  grant_a, grant_b, digits, blank, owner, busy, ovf
  );

  modport slave (
    input  req_a, val_a, req_b, val_b,
    output grant_a, grant_b, digits, blank, owner, busy, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble binary-to-BCD converter, one add-3-then-shift step per cycle, MSB first.
// Latency: VAL_W cycles after start; done is high in the cycle whose closing edge performs the last step.
// Backpressure: none; a start restarts the conversion and discards any value in flight.
module bin2bcd_seq
  import hex_sched_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int VAL_W      = 20
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic [VAL_W-1:0]            bin,
  output logic                        done,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd,
  output logic                        ovf
);
  localparam int BCD_TOT = BCD_W * NUM_DIGITS;
  localparam int CNT_W   = $clog2(VAL_W + 1);

  logic [VAL_W-1:0]   sh_q, sh_d;
  logic [BCD_TOT-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [BCD_TOT-1:0] adj;

  // Add 3 to every nibble that is 5 or more before the shift.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[i*BCD_W +: BCD_W] = (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) ?
                              bcd_q[i*BCD_W +: BCD_W] + 4'd3 :
                              bcd_q[i*BCD_W +: BCD_W];
    end
  end

  // Load on start, otherwise shift one binary bit into the BCD register per cycle.
  // Digits above NUM_DIGITS are dropped; the latched ovf flag overrides them.
  always_comb begin
    sh_d  = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CNT_W'(VAL_W);
      ovf_d = (64'(bin) >= pow10(NUM_DIGITS));
    end else if (cnt_q != '0) begin
      bcd_d = BCD_TOT'({adj, sh_q[VAL_W-1]});
      sh_d  = {sh_q[VAL_W-2:0], 1'b0};
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Converter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign done = (cnt_q == CNT_W'(1)) && !start;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;
endmodule

// File: rtl/hex_display_sched.sv
// Shares the HEX digit bank between score (A) and debug (B) sources; optional HEX_SCHED_BLANK_EN blanks leading zeros.
// Latency: grant at E0, display updated atomically at E(VAL_W+1); busy spans E0..E(VAL_W+1).
// Backpressure: requests wait in IDLE; while hold runs only the current owner may refresh.
module hex_display_sched
  import hex_sched_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int VAL_W       = 20,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic               clock,
  input  logic               reset,
  hex_display_sched_if.slave bus
);
  localparam int                DW          = BCD_W * NUM_DIGITS;
  localparam int                HOLD_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES);

  logic [1:0]            state_q, state_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  last_q, last_d;
  logic                  owner_q, owner_d;
  logic                  grant_a_q, grant_a_d;
  logic                  grant_b_q, grant_b_d;
  logic                  busy_q, busy_d;
  logic                  ovf_q, ovf_d;
  logic [DW-1:0]         digits_q, digits_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  logic                  elig_a, elig_b, pick_a, pick_b;
  logic                  conv_start, conv_done, conv_ovf;
  logic [VAL_W-1:0]      conv_bin;
  logic [DW-1:0]         conv_bcd, shown;
  logic [NUM_DIGITS-1:0] shown_blank;
`ifdef HEX_SCHED_BLANK_EN
  logic                  lead;
`endif

  // Eligibility is gated by the hold window; ties go to the source not granted last.
  always_comb begin
    elig_a     = bus.req_a && ((hold_q == '0) || (owner_q == OWNER_A));
    elig_b     = bus.req_b && ((hold_q == '0) || (owner_q == OWNER_B));
    pick_a     = elig_a && (!elig_b || (last_q == OWNER_B));
    pick_b     = elig_b && !pick_a;
    conv_start = (state_q == ST_IDLE) && (pick_a || pick_b);
    conv_bin   = pick_b ? bus.val_b : bus.val_a;
  end

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VAL_W      (VAL_W)
  ) u_conv (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Display image (saturated to all nines on overflow) and its blank mask.
  always_comb begin
    shown       = conv_ovf ? {NUM_DIGITS{4'h9}} : conv_bcd;
    shown_blank = '0;
`ifdef HEX_SCHED_BLANK_EN
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lead           = lead && (shown[i*BCD_W +: BCD_W] == 4'd0);
      shown_blank[i] = lead;
    end
`endif
  end

  // Scheduler FSM: grant in IDLE, wait for the converter, publish everything in LOAD.
  always_comb begin
    state_d   = state_q;
    hold_d    = (hold_q != '0) ? hold_q - HOLD_W'(1) : hold_q;
    last_d    = last_q;
    owner_d   = owner_q;
    grant_a_d = 1'b0;
    grant_b_d = 1'b0;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    digits_d  = digits_q;
    blank_d   = blank_q;
    case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          grant_a_d = pick_a;
          grant_b_d = pick_b;
          last_d    = pick_b ? OWNER_B : OWNER_A;
          busy_d    = 1'b1;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (conv_done) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        digits_d = shown;
        blank_d  = shown_blank;
        ovf_d    = conv_ovf;
        owner_d  = last_q;
        hold_d   = HOLD_RELOAD;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scheduler registers; reset discards any conversion in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      last_q    <= OWNER_B;
      owner_q   <= OWNER_A;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      digits_q  <= '0;
      blank_q   <= '1;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      grant_a_q <= grant_a_d;
      grant_b_q <= grant_b_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      digits_q  <= digits_d;
      blank_q   <= blank_d;
    end
  end

  assign bus.grant_a = grant_a_q;
  assign bus.grant_b = grant_b_q;
  assign bus.digits  = digits_q;
  assign bus.blank   = blank_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_hex_display_sched.sv
// Bench for hex_display_sched: directed scenarios plus randomized requests against a transaction model.
// Latency: model predicts grant at E0 and display update VAL_W+1 edges later.
// Backpressure: model applies the hold window and round-robin rules directly.
module tb_hex_display_sched;
  localparam int ND   = 6;
  localparam int VW   = 20;
  localparam int HOLD = 20;

`ifdef HEX_SCHED_BLANK_EN
  localparam logic [5:0] BL_42 = 6'b111100;
  localparam logic [5:0] BL_0  = 6'b111110;
  localparam logic [5:0] BL_9  = 6'b111110;
`else
  localparam logic [5:0] BL_42 = 6'b000000;
  localparam logic [5:0] BL_0  = 6'b000000;
  localparam logic [5:0] BL_9  = 6'b000000;
`endif

  logic clk;
  logic rst = 1'b1;

  hex_display_sched_if #(.NUM_DIGITS(ND), .VAL_W(VW)) bus ();

  hex_display_sched #(
    .NUM_DIGITS  (ND),
    .VAL_W       (VW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cnt;     // edges left until the display update, 0 = idle
  int          m_hold;
  int unsigned m_val;
  logic        m_src, m_last, m_owner, m_ovf, m_ga, m_gb, m_busy;
  logic [23:0] m_digits;
  logic [5:0]  m_blank;

  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] exp_blank(input int unsigned v);
    logic [5:0] b;
    b = '0;
`ifdef HEX_SCHED_BLANK_EN
    for (int i = 1; i < ND; i++) b[i] = (v < 32'(10 ** i));
`endif
    return b;
  endfunction

  task automatic m_reset();
    m_cnt = 0; m_hold = 0; m_val = 0;
    m_src = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_ovf = 1'b0;
    m_ga = 1'b0; m_gb = 1'b0; m_busy = 1'b0;
    m_digits = '0; m_blank = 6'h3f;
  endtask

  task automatic m_step();
    logic ea, eb, take_b;
    int unsigned shown;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (m_cnt == 0) begin
      ea = bus.req_a && (m_hold == 0 || m_owner == 1'b0);
      eb = bus.req_b && (m_hold == 0 || m_owner == 1'b1);
      if (m_hold > 0) m_hold--;
      if (ea || eb) begin
        take_b = eb && (!ea || m_last == 1'b0);
        m_src  = take_b;
        m_last = take_b;
        m_val  = take_b ? 32'(bus.val_b) : 32'(bus.val_a);
        m_ga   = !take_b;
        m_gb   = take_b;
        m_cnt  = VW + 1;
      end
    end else begin
      m_cnt--;
      if (m_hold > 0) m_hold--;
      if (m_cnt == 0) begin
        m_ovf    = (m_val >= 32'd1_000_000);
        shown    = m_ovf ? 32'd999_999 : m_val;
        m_digits = to_bcd(shown);
        m_blank  = exp_blank(shown);
        m_owner  = m_src;
        m_hold   = HOLD;
      end
    end
    m_busy = (m_cnt != 0);
  endtask

  task automatic compare_all();
    chk("grant_a", 64'(bus.grant_a), 64'(m_ga));
    chk("grant_b", 64'(bus.grant_b), 64'(m_gb));
    chk("busy",    64'(bus.busy),    64'(m_busy));
    chk("owner",   64'(bus.owner),   64'(m_owner));
    chk("ovf",     64'(bus.ovf),     64'(m_ovf));
    chk("digits",  64'(bus.digits),  64'(m_digits));
    chk("blank",   64'(bus.blank),   64'(m_blank));
  endtask

  // Model/compare process: advances on each clock edge or reset assertion.
  initial begin
    m_reset();
    #1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
      #1;
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    #2;
    rst = 1'b1;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"},  64'(bus.digits),  64'd0);
    chk({tag, "_blank"},   64'(bus.blank),   64'h3f);
    chk({tag, "_owner"},   64'(bus.owner),   64'd0);
    chk({tag, "_busy"},    64'(bus.busy),    64'd0);
    chk({tag, "_ovf"},     64'(bus.ovf),     64'd0);
    chk({tag, "_grants"},  64'({bus.grant_a, bus.grant_b}), 64'd0);
  endtask

  task automatic wait_grant(input logic want_b, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if ((want_b ? bus.grant_b : bus.grant_a) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic serve_a(input logic [19:0] v);
    bus.req_a = 1'b1;
    bus.val_a = v;
    tick();
    chk("serve_grant_a", 64'(bus.grant_a), 64'd1);
    bus.req_a = 1'b0;
    repeat (VW + 1) tick();
  endtask

  function automatic logic [19:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 20'($urandom_range(0, 99));
      1:       return 20'($urandom_range(999_990, 1_000_010));
      2:       return 20'($urandom_range(0, 1_048_575));
      default: return 20'd0;
    endcase
  endfunction

  initial begin
    int n;
    int gcount;
    bus.req_a = 1'b0; bus.val_a = '0;
    bus.req_b = 1'b0; bus.val_b = '0;

    // Reset state
    repeat (3) tick();
    chk_reset_vals("rst_held");
    rst = 1'b0;
    tick();
    chk_reset_vals("rst_idle");

    // Lone A request, value 123456
    bus.req_a = 1'b1;
    bus.val_a = 20'd123456;
    tick();
    chk("t1_grant_a", 64'(bus.grant_a), 64'd1);
    chk("t1_busy_e0", 64'(bus.busy), 64'd1);
    bus.req_a = 1'b0;
    repeat (VW) tick();
    chk("t1_busy_e20",   64'(bus.busy),   64'd1);
    chk("t1_digits_e20", 64'(bus.digits), 64'd0);
    tick();
    chk("t1_digits_e21", 64'(bus.digits), 64'h123456);
    chk("t1_busy_e21",   64'(bus.busy),   64'd0);
    chk("t1_owner",      64'(bus.owner),  64'd0);
    chk("t1_blank",      64'(bus.blank),  64'd0);

    // Both sources from reset: A first, B after hold expiry
    assert_reset();
    chk_reset_vals("t2_rst");
    repeat (2) tick();
    rst = 1'b0;
    bus.req_a = 1'b1; bus.val_a = 20'd111;
    bus.req_b = 1'b1; bus.val_b = 20'd222222;
    tick();
    chk("t2_grant_a", 64'(bus.grant_a), 64'd1);
    chk("t2_grant_b", 64'(bus.grant_b), 64'd0);
    bus.req_a = 1'b0;
    wait_grant(1'b1, 80, n);
    chk("t2_b_delay", 64'(n), 64'd42);
    bus.req_b = 1'b0;
    repeat (VW + 1) tick();
    chk("t2_owner_b",  64'(bus.owner),  64'd1);
    chk("t2_digits_b", 64'(bus.digits), 64'h222222);

    // Owner A refresh during hold beats B; then B waits out the hold
    repeat (25) tick();
    serve_a(20'd777);
    chk("t3_owner_a", 64'(bus.owner), 64'd0);
    repeat (3) tick();
    bus.req_a = 1'b1; bus.val_a = 20'd888;
    bus.req_b = 1'b1; bus.val_b = 20'd31337;
    tick();
    chk("t3_refresh_a", 64'(bus.grant_a), 64'd1);
    chk("t3_no_b",      64'(bus.grant_b), 64'd0);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (VW + 1) tick();
    chk("t3_digits_888", 64'(bus.digits), 64'h000888);
    repeat (5) tick();
    bus.req_b = 1'b1;
    wait_grant(1'b1, 60, n);
    chk("t3_b_delay", 64'(n), 64'd16);
    bus.req_b = 1'b0;
    repeat (VW + 1) tick();
    chk("t3_digits_b", 64'(bus.digits), 64'h031337);

    // Overflow saturation and recovery, blanking
    repeat (25) tick();
    serve_a(20'd1_000_000);
    chk("t4_sat_digits", 64'(bus.digits), 64'h999999);
    chk("t4_sat_ovf",    64'(bus.ovf),    64'd1);
    serve_a(20'd42);
    chk("t4_42_digits", 64'(bus.digits), 64'h000042);
    chk("t4_42_ovf",    64'(bus.ovf),    64'd0);
    chk("t4_42_blank",  64'(bus.blank),  64'(BL_42));
    serve_a(20'd0);
    chk("t4_0_digits", 64'(bus.digits), 64'd0);
    chk("t4_0_blank",  64'(bus.blank),  64'(BL_0));

    // Reset in the middle of a conversion
    bus.req_a = 1'b1; bus.val_a = 20'd555;
    tick();
    chk("t5_grant", 64'(bus.grant_a), 64'd1);
    bus.req_a = 1'b0;
    repeat (10) tick();
    assert_reset();
    chk_reset_vals("t5_abort");
    repeat (2) tick();
    rst = 1'b0;
    gcount = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.grant_a || bus.grant_b) gcount++;
    end
    chk("t5_no_grant", 64'(gcount), 64'd0);
    serve_a(20'd9);
    chk("t5_digits_9", 64'(bus.digits), 64'h000009);
    chk("t5_blank_9",  64'(bus.blank),  64'(BL_9));

    // Randomized traffic; the model process checks every cycle
    for (int c = 0; c < 2500; c++) begin
      tick();
      if (bus.grant_a) begin
        if ($urandom_range(0, 1) == 0) bus.req_a = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.req_a = !bus.req_a;
        bus.val_a = rand_val();
      end
      if (bus.grant_b) begin
        if ($urandom_range(0, 1) == 0) bus.req_b = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        bus.req_b = !bus.req_b;
        bus.val_b = rand_val();
      end
      if ($urandom_range(0, 799) == 0) begin
        assert_reset();
        tick();
        rst = 1'b0;
      end
    end
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    repeat (VW + 3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
